// File: rtl/ext_tid_pkg.sv
// Shared types for the external transaction-ID allocator.
// Optional drain support is enabled with EXT_TID_ALLOC_DRAIN_EN.
package ext_tid_pkg;

    typedef enum logic {
        TID_LOWEST = 1'b0,
        TID_RR     = 1'b1
    } alloc_mode_e;

    typedef enum logic {
        DRAIN_RUN    = 1'b0,
        DRAIN_ACTIVE = 1'b1
    } drain_state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ext_tid_alloc_ff_rot.sv
// Rotating find-first-set over the first NB_ENTRIES bits of a vector.
// Search starts at start_i and wraps modulo NB_ENTRIES.
module ext_tid_ff_rot #(
    parameter int unsigned IDX_WIDTH  = 4,
    parameter int unsigned NB_ENTRIES = 16
) (
    input  logic [2**IDX_WIDTH-1:0] vec_i,
    input  logic [IDX_WIDTH-1:0]    start_i,
    output logic [IDX_WIDTH-1:0]    idx_o,
    output logic                    found_o
);

    localparam logic [IDX_WIDTH:0] NB_L = (IDX_WIDTH+1)'(NB_ENTRIES);

    logic [IDX_WIDTH:0] pos;

    always_comb begin
        pos     = '0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NB_ENTRIES; i++) begin
            pos = {1'b0, start_i} + (IDX_WIDTH+1)'(i);
            if (pos >= NB_L) begin
                pos = pos - NB_L;
            end
            if (!found_o && vec_i[pos[IDX_WIDTH-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/ext_tid_alloc.sv
// External transaction-ID allocator with per-ID metadata and status.
// Define EXT_TID_ALLOC_DRAIN_EN to add the drain_req_i/drain_done_o FSM.
module ext_tid_alloc
    import ext_tid_pkg::*;
#(
    parameter int unsigned EXT_TID_WIDTH   = 4,
    parameter int unsigned NB_OUTSND_TRANS = 2**EXT_TID_WIDTH,
    parameter int unsigned ALLOC_MODE      = 0,
    parameter int unsigned META_WIDTH      = 8,
    localparam int unsigned CNT_WIDTH      = cnt_width(NB_OUTSND_TRANS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef EXT_TID_ALLOC_DRAIN_EN
    input  logic                     drain_req_i,
    output logic                     drain_done_o,
`endif
    output logic                     alloc_valid_o,
    output logic [EXT_TID_WIDTH-1:0] alloc_tid_o,
    input  logic                     alloc_ready_i,
    input  logic [META_WIDTH-1:0]    alloc_meta_i,
    input  logic                     release_valid_i,
    input  logic [EXT_TID_WIDTH-1:0] release_tid_i,
    output logic [META_WIDTH-1:0]    release_meta_o,
    output logic                     release_err_o,
    output logic [CNT_WIDTH-1:0]     outstanding_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned NB_IDS = 2**EXT_TID_WIDTH;
    localparam logic [EXT_TID_WIDTH:0] NB_L =
        (EXT_TID_WIDTH+1)'(NB_OUTSND_TRANS);
    localparam logic [EXT_TID_WIDTH-1:0] LAST_ID =
        EXT_TID_WIDTH'(NB_OUTSND_TRANS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL =
        CNT_WIDTH'(NB_OUTSND_TRANS);

    logic [NB_IDS-1:0]        busy_q, busy_d;
    logic [NB_IDS-1:0]        id_mask;
    logic [NB_IDS-1:0]        free_vec;
    logic [EXT_TID_WIDTH-1:0] ptr_q, ptr_d;
    logic [EXT_TID_WIDTH-1:0] start;
    logic [EXT_TID_WIDTH-1:0] sel_id;
    logic                     sel_found;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     alloc_gate;
    logic                     alloc_fire;
    logic                     rel_legal;
    logic [META_WIDTH-1:0]    meta_q [NB_IDS];

    for (genvar i = 0; i < NB_IDS; i++) begin : g_mask
        assign id_mask[i] = (i < NB_OUTSND_TRANS);
    end

    assign free_vec = ~busy_q & id_mask;
    assign start    = (ALLOC_MODE == 1) ? ptr_q : '0;

    ext_tid_ff_rot #(
        .IDX_WIDTH (EXT_TID_WIDTH),
        .NB_ENTRIES(NB_OUTSND_TRANS)
    ) i_ff_rot (
        .vec_i  (free_vec),
        .start_i(start),
        .idx_o  (sel_id),
        .found_o(sel_found)
    );

    assign alloc_valid_o = sel_found && !alloc_gate;
    assign alloc_tid_o   = alloc_valid_o ? sel_id : '0;
    assign alloc_fire    = alloc_valid_o && alloc_ready_i;

    // Out-of-range IDs are never busy, so they always count as illegal.
    assign rel_legal = release_valid_i
                     && ({1'b0, release_tid_i} < NB_L)
                     && busy_q[release_tid_i];

    always_comb begin
        busy_d = busy_q;
        if (alloc_fire) begin
            busy_d[sel_id] = 1'b1;
        end
        if (rel_legal) begin
            busy_d[release_tid_i] = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (alloc_fire && (ALLOC_MODE == 1)) begin
            ptr_d = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({alloc_fire, rel_legal})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign err_d = release_valid_i && !rel_legal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            meta_q[sel_id] <= alloc_meta_i;
        end
    end

    assign release_meta_o = meta_q[release_tid_i];
    assign release_err_o  = err_q;
    assign outstanding_o  = cnt_q;
    assign full_o         = (cnt_q == CNT_FULL);
    assign empty_o        = (cnt_q == '0);

`ifdef EXT_TID_ALLOC_DRAIN_EN
    drain_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DRAIN_RUN:    if (drain_req_i) state_d = DRAIN_ACTIVE;
            DRAIN_ACTIVE: if (empty_o && !drain_req_i) state_d = DRAIN_RUN;
            default:      state_d = DRAIN_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DRAIN_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign alloc_gate   = (state_q == DRAIN_ACTIVE);
    assign drain_done_o = (state_q == DRAIN_ACTIVE) && empty_o;
`else
    assign alloc_gate = 1'b0;
`endif

endmodule

// File: tb/tb_ext_tid_alloc.sv
// Random and directed checks of ext_tid_alloc against a behavioural model.
// Three instances: lowest-free N=16, round-robin N=4, round-robin N=12.
module tb_ext_tid_alloc;

    localparam int NG = 3;

    function automatic int nb_of(input int g);
        case (g)
            0:       return 16;
            1:       return 4;
            default: return 12;
        endcase
    endfunction

    function automatic int mode_of(input int g);
        return (g == 0) ? 0 : 1;
    endfunction

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    logic [NG-1:0]      ar;
    logic [NG-1:0][7:0] am;
    logic [NG-1:0]      rv;
    logic [NG-1:0][3:0] rt;
    logic [NG-1:0]      av;
    logic [NG-1:0][3:0] at;
    logic [NG-1:0][7:0] rm;
    logic [NG-1:0]      re;
    logic [NG-1:0][4:0] oc;
    logic [NG-1:0]      fu;
    logic [NG-1:0]      em;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < NG; g++) begin : gi
        localparam int N = nb_of(g);
        logic [$clog2(N+1)-1:0] cnt;
`ifdef EXT_TID_ALLOC_DRAIN_EN
        logic dd;
`endif
        ext_tid_alloc #(
            .EXT_TID_WIDTH  (4),
            .NB_OUTSND_TRANS(N),
            .ALLOC_MODE     (mode_of(g)),
            .META_WIDTH     (8)
        ) u_dut (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
`ifdef EXT_TID_ALLOC_DRAIN_EN
            .drain_req_i    (1'b0),
            .drain_done_o   (dd),
`endif
            .alloc_valid_o  (av[g]),
            .alloc_tid_o    (at[g]),
            .alloc_ready_i  (ar[g]),
            .alloc_meta_i   (am[g]),
            .release_valid_i(rv[g]),
            .release_tid_i  (rt[g]),
            .release_meta_o (rm[g]),
            .release_err_o  (re[g]),
            .outstanding_o  (cnt),
            .full_o         (fu[g]),
            .empty_o        (em[g])
        );
        assign oc[g] = 5'(cnt);
    end

    bit         mbusy [NG][16];
    logic [7:0] mmeta [NG][16];
    int         mptr  [NG];
    int         mcnt  [NG];
    bit         merr  [NG];
    bit         ev    [NG];
    int         et    [NG];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Offer from the model: first free ID scanning from the start point.
    function automatic void model_offer(input int g);
        int n = nb_of(g);
        int k;
        ev[g] = 0;
        et[g] = 0;
        for (int i = 0; i < n; i++) begin
            k = (mode_of(g) == 1) ? (mptr[g] + i) % n : i;
            if (!ev[g] && !mbusy[g][k]) begin
                ev[g] = 1;
                et[g] = k;
            end
        end
    endfunction

    task automatic compare(input int g);
        int n = nb_of(g);
        model_offer(g);
        chk($sformatf("g%0d valid", g), int'(av[g]), int'(ev[g]));
        chk($sformatf("g%0d tid", g), int'(at[g]), et[g]);
        chk($sformatf("g%0d cnt", g), int'(oc[g]), mcnt[g]);
        chk($sformatf("g%0d full", g), int'(fu[g]), int'(mcnt[g] == n));
        chk($sformatf("g%0d empty", g), int'(em[g]), int'(mcnt[g] == 0));
        chk($sformatf("g%0d err", g), int'(re[g]), int'(merr[g]));
        if (rv[g] && int'(rt[g]) < n && mbusy[g][rt[g]]) begin
            chk($sformatf("g%0d meta", g), int'(rm[g]), int'(mmeta[g][rt[g]]));
        end
    endtask

    task automatic update(input int g);
        int  n     = nb_of(g);
        bit  legal = rv[g] && int'(rt[g]) < n && mbusy[g][rt[g]];
        bit  fire  = ev[g] && ar[g];
        if (fire) begin
            mbusy[g][et[g]] = 1;
            mmeta[g][et[g]] = am[g];
            mptr[g] = (et[g] + 1) % n;
        end
        if (legal) begin
            mbusy[g][rt[g]] = 0;
        end
        mcnt[g] = mcnt[g] + int'(fire) - int'(legal);
        merr[g] = rv[g] && !legal;
    endtask

    task automatic tick();
        #1;
        for (int g = 0; g < NG; g++) compare(g);
        @(posedge clk_i);
        for (int g = 0; g < NG; g++) update(g);
        @(negedge clk_i);
    endtask

    task automatic idle();
        ar = '0;
        am = '0;
        rv = '0;
        rt = '0;
    endtask

    initial begin
        idle();
        for (int g = 0; g < NG; g++) begin
            mptr[g] = 0;
            mcnt[g] = 0;
            merr[g] = 0;
            for (int k = 0; k < 16; k++) mbusy[g][k] = 0;
        end
        #3;
        for (int g = 0; g < NG; g++) begin
            chk($sformatf("rst g%0d empty", g), int'(em[g]), 1);
            chk($sformatf("rst g%0d full", g), int'(fu[g]), 0);
            chk($sformatf("rst g%0d cnt", g), int'(oc[g]), 0);
            chk($sformatf("rst g%0d err", g), int'(re[g]), 0);
            chk($sformatf("rst g%0d valid", g), int'(av[g]), 1);
            chk($sformatf("rst g%0d tid", g), int'(at[g]), 0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Lowest-free fill of all 16 IDs, ID 5 tagged with 0xA5.
        for (int i = 0; i < 16; i++) begin
            ar[0] = 1'b1;
            am[0] = (i == 5) ? 8'hA5 : 8'(i);
            #1;
            chk("fill0 order", int'(at[0]), i);
            tick();
        end
        ar[0] = 1'b0;
        #1;
        chk("fill0 full", int'(fu[0]), 1);
        chk("fill0 valid", int'(av[0]), 0);
        chk("fill0 cnt", int'(oc[0]), 16);

        rv[0] = 1'b1;
        rt[0] = 4'd5;
        #1;
        chk("rel5 meta", int'(rm[0]), 8'hA5);
        tick();
        rv[0] = 1'b0;
        #1;
        chk("rel5 reoffer", int'(at[0]), 5);
        chk("rel5 cnt", int'(oc[0]), 15);

        // Round-robin N=4: 0,1, release 0, then 2,3,0.
        ar[1] = 1'b1;
        #1;
        chk("rr4 first", int'(at[1]), 0);
        tick();
        chk("rr4 second", int'(at[1]), 1);
        tick();
        ar[1] = 1'b0;
        rv[1] = 1'b1;
        rt[1] = 4'd0;
        tick();
        rv[1] = 1'b0;
        ar[1] = 1'b1;
        #1;
        chk("rr4 after rel", int'(at[1]), 2);
        tick();
        chk("rr4 next", int'(at[1]), 3);
        tick();
        chk("rr4 wrap", int'(at[1]), 0);
        tick();
        ar[1] = 1'b0;
        #1;
        chk("rr4 full", int'(fu[1]), 1);

        // Illegal releases: free ID and out-of-range ID.
        rv[2] = 1'b1;
        rt[2] = 4'd3;
        tick();
        rv[2] = 1'b0;
        #1;
        chk("ill free err", int'(re[2]), 1);
        chk("ill free cnt", int'(oc[2]), 0);
        tick();
        chk("ill err pulse", int'(re[2]), 0);
        rv[2] = 1'b1;
        rt[2] = 4'd13;
        tick();
        rv[2] = 1'b0;
        #1;
        chk("ill range err", int'(re[2]), 1);

        // Simultaneous allocate ID 6 and release busy ID 2.
        for (int i = 0; i < 6; i++) begin
            ar[2] = 1'b1;
            #1;
            chk("rr12 order", int'(at[2]), i);
            tick();
        end
        rv[2] = 1'b1;
        rt[2] = 4'd2;
        #1;
        chk("both tid", int'(at[2]), 6);
        tick();
        ar[2] = 1'b0;
        rv[2] = 1'b0;
        #1;
        chk("both cnt", int'(oc[2]), 6);
        chk("both next", int'(at[2]), 7);
        rv[2] = 1'b1;
        rt[2] = 4'd2;
        tick();
        rt[2] = 4'd6;
        #1;
        chk("id2 freed", int'(re[2]), 1);
        tick();
        rv[2] = 1'b0;
        #1;
        chk("id6 busy", int'(re[2]), 0);
        chk("id6 rel cnt", int'(oc[2]), 5);

        // Fill N=12 and confirm ID 12 and above are never offered.
        ar[2] = 1'b1;
        repeat (10) tick();
        ar[2] = 1'b0;
        #1;
        chk("n12 full", int'(fu[2]), 1);
        chk("n12 cnt", int'(oc[2]), 12);
        chk("n12 valid", int'(av[2]), 0);
        chk("n12 tid", int'(at[2]), 0);

        // Randomised traffic, bias flipping between fill and drain epochs.
        for (int c = 0; c < 1600; c++) begin
            bit fill = ((c / 200) % 2) == 0;
            for (int g = 0; g < NG; g++) begin
                int cand[$];
                cand = {};
                for (int k = 0; k < nb_of(g); k++) begin
                    if (mbusy[g][k]) cand.push_back(k);
                end
                ar[g] = fill ? ($urandom_range(0, 3) != 0)
                             : ($urandom_range(0, 3) == 0);
                rv[g] = fill ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 3) != 0);
                am[g] = 8'($urandom);
                if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rt[g] = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                end else begin
                    rt[g] = 4'($urandom_range(0, 15));
                end
            end
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ext_tid_alloc.md
Name: ext_tid_alloc

Overview:
Parametrised external transaction-ID allocator for the mchan external unit. It is the successor of the fixed 16-entry TID generator.
- Supports any ID width and any outstanding depth.
- Selectable lowest-free or round-robin allocation policy.
- Stores per-ID metadata and returns it when the ID is released.
- Provides an outstanding counter, full/empty status and an illegal-release error flag.

Parameters:
EXT_TID_WIDTH, 4, width of the transaction ID; 1..8.
NB_OUTSND_TRANS, 2**EXT_TID_WIDTH, number of usable IDs; 1..2**EXT_TID_WIDTH. IDs >= NB_OUTSND_TRANS are never issued.
ALLOC_MODE, 0, 0 = lowest free ID first; 1 = round-robin, searching from last issued ID + 1.
META_WIDTH, 8, width of the per-ID metadata stored at allocation.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
alloc_valid_o  out  1  a free ID is offered
alloc_tid_o  out  EXT_TID_WIDTH  offered ID; 0 when alloc_valid_o=0
alloc_ready_i  in  1  consumer takes the offered ID
alloc_meta_i  in  META_WIDTH  metadata stored with the taken ID
release_valid_i  in  1  release request
release_tid_i  in  EXT_TID_WIDTH  ID being released
release_meta_o  out  META_WIDTH  metadata of release_tid_i, combinational read
release_err_o  out  1  registered one-cycle pulse: illegal release
outstanding_o  out  $clog2(NB_OUTSND_TRANS+1)  number of IDs currently allocated
full_o  out  1  outstanding_o == NB_OUTSND_TRANS
empty_o  out  1  outstanding_o == 0

Behaviour:
- Reset state (async, rst_ni low):
  - all IDs free; round-robin pointer 0; outstanding_o 0.
  - empty_o 1, full_o 0, release_err_o 0.
  - metadata RAM not reset; release_meta_o is undefined for never-allocated IDs.
- Offer (combinational from state):
  - alloc_valid_o = any free ID below NB_OUTSND_TRANS.
  - alloc_tid_o = selected free ID, else 0.
- Selection:
  - Mode 0: lowest-index free ID.
  - Mode 1: first free ID at or after ptr, wrapping modulo NB_OUTSND_TRANS. ptr updates to issued ID + 1 (wrapping) on each accepted allocation.
- Allocation handshake:
  - Fires when alloc_valid_o && alloc_ready_i.
  - At the next edge the ID is marked busy and alloc_meta_i is written to meta[ID].
  - alloc_ready_i while alloc_valid_o=0 is ignored: no state change.
  - At most one allocation per cycle.
- Release:
  - When release_valid_i is high with a busy ID below NB_OUTSND_TRANS, the ID is marked free at the next edge.
  - release_meta_o is valid in the same cycle.
  - A freed ID is offered no earlier than the following cycle; there is no same-cycle bypass.
- Illegal release:
  - Applies to an ID that is free or >= NB_OUTSND_TRANS.
  - Table and counter are unchanged.
  - release_err_o pulses high for one cycle after the edge.
- Simultaneous allocation and release in one cycle:
  - Both take effect; outstanding_o is unchanged.
  - They cannot target the same ID, because the released ID is busy and the offered ID is free.
- Counter: +1 on allocation only, -1 on legal release only; it never wraps. When full, alloc_valid_o=0.
- Latency: allocation and release are both visible in status one cycle after the edge.

Optional Feature:
EXT_TID_ALLOC_DRAIN_EN
- Defined: adds drain_req_i (in, 1) and drain_done_o (out, 1), plus a two-state FSM.
  - RUN -> DRAIN on drain_req_i.
  - In DRAIN, alloc_valid_o is forced 0 and releases proceed normally.
  - DRAIN -> RUN when outstanding_o == 0 and drain_req_i == 0.
  - drain_done_o = (state == DRAIN) && empty_o.
  - Reset state is RUN.
- Undefined: neither port nor the FSM exists; allocation is never gated.

Decomposition:
- Package ext_tid_pkg holds:
  - the alloc_mode_e enum (TID_LOWEST = 0, TID_RR = 1);
  - the drain state enum;
  - the helper function for counter width.
- Sub-module ext_tid_ff_rot:
  - parametrised rotating find-first-set;
  - inputs: free vector and start index; outputs: index and found.
  - Mode 0 ties start to 0.

Test Plan:
- Reset, mode 0, W=4, N=16: alloc_ready_i held 16 cycles -> IDs 0..15 in order; then full_o=1, alloc_valid_o=0, outstanding_o=16.
- Mode 0, all busy: release ID 5 with meta written as 0xA5 -> release_meta_o=0xA5 that cycle; next cycle alloc_tid_o=5, outstanding_o=15.
- Mode 1, N=4: allocate 0,1; release 0; allocate -> ID 2, then ID 3, then ID 0. ptr wraps correctly.
- Release an already-free ID 3 -> release_err_o=1 for exactly one cycle; outstanding_o and table unchanged.
- Same cycle: allocate ID 6 and release busy ID 2 -> outstanding_o unchanged; next cycle ID 2 free and ID 6 busy.
- N=12, W=4: allocate 12 -> full_o=1, ID 12 never offered. With DRAIN_EN and drain_req_i pulsed while 3 are outstanding: alloc_valid_o=0, drain_done_o=1 the cycle after the last release.
